hist_bins_v3: RTL

HIST_BINS_V3 -- requirements
Module: hist_bins_v3

---
 rtl/hist_pkg.sv | 22 ++
 rtl/hist_line_cntr.sv | 41 ++++
 rtl/hist_bins_v3.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/hist_pkg.sv
// Shared definitions for the sign/magnitude histogram block: FSM states and bin indices.
package hist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DUMP = 2'd2
    } state_t;

    localparam int NBINS = 4;

    localparam logic [1:0] BIN_00 = 2'd0;
    localparam logic [1:0] BIN_01 = 2'd1;
    localparam logic [1:0] BIN_10 = 2'd2;
    localparam logic [1:0] BIN_11 = 2'd3;

    // Bin index is the {sig,mag} pair taken as a 2-bit number.
    function automatic logic [1:0] bin_of(input logic s, input logic m);
        return {s, m};
    endfunction

endpackage

// File: rtl/hist_line_cntr.sv
// Four bin counters for one sig/mag line, with a result snapshot taken on copy.
module hist_line_cntr
    import hist_pkg::*;
#(
    parameter int CNTR_W = 16
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    inc,
    input  logic [1:0]              bin_sel,
    input  logic                    clr,
    input  logic                    copy,
    output logic [NBINS*CNTR_W-1:0] res
);

    logic [CNTR_W-1:0] cnt [NBINS];

    // Copy samples the pre-clear counts, so copy and clear may share a cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int b = 0; b < NBINS; b++) begin
                cnt[b]                  <= '0;
                res[b*CNTR_W +: CNTR_W] <= '0;
            end
        end else begin
            if (copy) begin
                for (int b = 0; b < NBINS; b++) begin
                    res[b*CNTR_W +: CNTR_W] <= cnt[b];
                end
            end
            if (clr) begin
                for (int b = 0; b < NBINS; b++) begin
                    cnt[b] <= '0;
                end
            end else if (inc) begin
                cnt[bin_sel] <= cnt[bin_sel] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/hist_bins_v3.sv
// Windowed sign/magnitude histogram over LINES lines with a readable result buffer.
// Optional interrupt output enabled by defining HIST_BINS_IRQ_EN.
module hist_bins_v3
    import hist_pkg::*;
#(
    parameter int LINES  = 4,
    parameter int CNTR_W = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [LINES-1:0]  sig,
    input  logic [LINES-1:0]  mag,
    input  logic              sample_en,
    input  logic [CNTR_W-1:0] win_len,
    input  logic              cont,
    input  logic              start,
    input  logic              stop,
    input  logic              rd_req,
    input  logic [7:0]        rd_line,
    input  logic [1:0]        rd_bin,
    output logic [CNTR_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done,
`ifdef HIST_BINS_IRQ_EN
    output logic              irq,
    input  logic              irq_clr,
`endif
    output logic [7:0]        frame_cnt
);

    state_t state, state_nxt;

    logic [CNTR_W-1:0] win_len_q;
    logic              cont_q;
    logic [CNTR_W-1:0] win_cnt;
    logic [CNTR_W-1:0] win_cnt_inc;
    logic              run_smp;
    logic              clr_bins;
    logic              copy_res;
    logic              accept_start;

    logic [LINES*NBINS*CNTR_W-1:0] res_bus;
    logic [CNTR_W-1:0]             rd_sel;

    assign win_cnt_inc  = win_cnt + 1'b1;
    assign accept_start = (state == ST_IDLE) && (state_nxt == ST_RUN);
    assign busy         = (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        run_smp   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop && (win_len != '0))
                    state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (stop) begin
                    state_nxt = ST_IDLE;
                end else if (sample_en) begin
                    run_smp = 1'b1;
                    if (win_cnt_inc == win_len_q)
                        state_nxt = ST_DUMP;
                end
            end
            ST_DUMP: begin
                state_nxt = (cont_q && !stop) ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign copy_res = (state == ST_DUMP);
    assign clr_bins = copy_res || ((state == ST_RUN) && stop);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            win_len_q <= '0;
            cont_q    <= 1'b0;
            win_cnt   <= '0;
            done      <= 1'b0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept_start) begin
                win_len_q <= win_len;
                cont_q    <= cont;
            end
            if (clr_bins)
                win_cnt <= '0;
            else if (run_smp)
                win_cnt <= win_cnt_inc;
            done <= copy_res;
            if (copy_res)
                frame_cnt <= frame_cnt + 1'b1;
        end
    end

    for (genvar l = 0; l < LINES; l++) begin : gen_line
        hist_line_cntr #(
            .CNTR_W (CNTR_W)
        ) u_line (
            .clk     (clk),
            .resetn  (resetn),
            .inc     (run_smp),
            .bin_sel (bin_of(sig[l], mag[l])),
            .clr     (clr_bins),
            .copy    (copy_res),
            .res     (res_bus[l*NBINS*CNTR_W +: NBINS*CNTR_W])
        );
    end

    // Out-of-range lines match no entry and read back as zero.
    always_comb begin
        rd_sel = '0;
        for (int i = 0; i < LINES; i++) begin
            if (rd_line == 8'(i))
                rd_sel = res_bus[(i*NBINS + int'(rd_bin))*CNTR_W +: CNTR_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req)
                rd_data <= rd_sel;
        end
    end

`ifdef HIST_BINS_IRQ_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            irq <= 1'b0;
        else if (copy_res)
            irq <= 1'b1;
        else if (irq_clr)
            irq <= 1'b0;
    end
`endif

endmodule
